// File: rtl/fp_pkg.sv
// Shared definitions for the FP multiplier datapath: default field widths,
// exponent bias and shift-width helpers, and the exponent class encoding.
package fp_pkg;

    localparam int unsigned EXP_W_DEF  = 8;
    localparam int unsigned MANT_W_DEF = 23;

    typedef enum logic [1:0] {
        CLS_NORM,
        CLS_DENORM,
        CLS_INF,
        CLS_OVF
    } exp_cls_e;

    // Standard IEEE-style bias for an exponent field of the given width
    function automatic int unsigned bias_of(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    // Wide enough to hold the saturated shift MANT_W+2
    function automatic int unsigned shift_w_of(input int unsigned mant_w);
        return $clog2(mant_w + 3);
    endfunction

endpackage

// File: rtl/exp_sum_classify.sv
// Combinational classifier for a biased product exponent: decides between
// normal / denormal / exact-inf / overflow and derives the denormalising
// right-shift, saturated so the mantissa flushes to zero past MANT_W+1.
module exp_sum_classify
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W    = EXP_W_DEF,
    parameter int unsigned MANT_W   = MANT_W_DEF,
    localparam int unsigned SUM_W   = EXP_W + 2,
    localparam int unsigned SHIFT_W = shift_w_of(MANT_W)
) (
    input  logic [SUM_W-1:0]   sum,
    output exp_cls_e           cls,
    output logic [SHIFT_W-1:0] shift,
    output logic               ftz,
    output logic [EXP_W-1:0]   res_exp
);

    localparam logic [SUM_W-1:0]   INF_SUM   = SUM_W'((1 << EXP_W) - 1);
    localparam logic [31:0]        FTZ_LIMIT = 32'(MANT_W + 1);
    localparam logic [SHIFT_W-1:0] SAT_SHIFT = SHIFT_W'(MANT_W + 2);

    logic [SUM_W-1:0] neg_shift;

    // Ordered classification; sum is two's complement and never wraps
    always_comb begin
        neg_shift = SUM_W'(1) - sum;
        cls       = CLS_NORM;
        shift     = '0;
        ftz       = 1'b0;
        res_exp   = sum[EXP_W-1:0];
        if (sum[SUM_W-1] || (sum == '0)) begin
            cls     = CLS_DENORM;
            res_exp = '0;
            if (32'(neg_shift) > FTZ_LIMIT) begin
                shift = SAT_SHIFT;
                ftz   = 1'b1;
            end else begin
                shift = SHIFT_W'(neg_shift);
            end
        end else if (sum == INF_SUM) begin
            cls = CLS_INF;
        end else if (sum[EXP_W]) begin
            // Positive and bit EXP_W set: sum >= 2^EXP_W
            cls = CLS_OVF;
        end
    end

endmodule

// File: rtl/exp_sum_analiz_pipe.sv
// Two-stage exponent-sum analyser for the FP multiplier. S1 forms the biased
// product exponent, S2 registers its classification and denormalising shift.
// Valid/ready on both sides; in_ready is the only combinational ready path.
module exp_sum_analiz_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W    = EXP_W_DEF,
    parameter int unsigned MANT_W   = MANT_W_DEF,
    parameter int unsigned BIAS     = bias_of(EXP_W),
    parameter int unsigned TAG_W    = 4,
    localparam int unsigned SUM_W   = EXP_W + 2,
    localparam int unsigned SHIFT_W = shift_w_of(MANT_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EXP_W-1:0]   in_exp_a,
    input  logic [EXP_W-1:0]   in_exp_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W-1:0]   out_exp,
    output logic [SHIFT_W-1:0] out_denorm_shift,
    output logic               out_denorm,
    output logic               out_ftz,
    output logic               out_inf,
    output logic               out_overflow,
    output logic [TAG_W-1:0]   out_tag
);

    logic               ready_en_q;
    logic               s1_valid_q;
    logic [SUM_W-1:0]   s1_sum_q;
    logic [TAG_W-1:0]   s1_tag_q;
    logic [SUM_W-1:0]   sum_d;
    logic               s2_can_load;
    logic               in_fire;
    exp_cls_e           cls;
    logic [SHIFT_W-1:0] cls_shift;
    logic               cls_ftz;
    logic [EXP_W-1:0]   cls_exp;

    assign s2_can_load = ~out_valid | out_ready;
    // ready_en_q keeps in_ready low during reset and for the first edge after
    assign in_ready    = ready_en_q & (~s1_valid_q | s2_can_load);
    assign in_fire     = in_valid & in_ready;
    assign sum_d       = {2'b00, in_exp_a} + {2'b00, in_exp_b} - SUM_W'(BIAS);

    // Enable input acceptance one cycle after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // S1 occupancy: refill whenever it is empty or draining into S2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_fire;
        end
    end

    // S1 data: biased sum and tag captured on an accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sum_q <= '0;
            s1_tag_q <= '0;
        end else if (in_fire) begin
            s1_sum_q <= sum_d;
            s1_tag_q <= in_tag;
        end
    end

    exp_sum_classify #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W)
    ) u_classify (
        .sum     (s1_sum_q),
        .cls     (cls),
        .shift   (cls_shift),
        .ftz     (cls_ftz),
        .res_exp (cls_exp)
    );

    // S2 occupancy: output beat held until the consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_can_load) begin
            out_valid <= s1_valid_q;
        end
    end

    // S2 data: only updated when a real beat moves in, so stalled outputs hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_exp          <= '0;
            out_denorm_shift <= '0;
            out_denorm       <= 1'b0;
            out_ftz          <= 1'b0;
            out_inf          <= 1'b0;
            out_overflow     <= 1'b0;
            out_tag          <= '0;
        end else if (s2_can_load && s1_valid_q) begin
            out_exp          <= cls_exp;
            out_denorm_shift <= cls_shift;
            out_denorm       <= (cls == CLS_DENORM);
            out_ftz          <= cls_ftz;
            out_inf          <= (cls == CLS_INF);
            out_overflow     <= (cls == CLS_OVF);
            out_tag          <= s1_tag_q;
        end
    end

endmodule

// File: tb/tb_exp_sum_analiz_pipe.sv
// Scoreboard bench for exp_sum_analiz_pipe (EXP_W=8, MANT_W=23, BIAS=127).
module tb_exp_sum_analiz_pipe;

    typedef struct packed {
        logic [7:0] e;
        logic [4:0] sh;
        logic       dn;
        logic       ftz;
        logic       inf;
        logic       ovf;
        logic [3:0] tag;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_exp_a = '0;
    logic [7:0] in_exp_b = '0;
    logic [3:0] in_tag = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_exp;
    logic [4:0] out_denorm_shift;
    logic       out_denorm;
    logic       out_ftz;
    logic       out_inf;
    logic       out_overflow;
    logic [3:0] out_tag;

    res_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   n_out = 0;
    bit   rand_ready = 1'b0;

    exp_sum_analiz_pipe #(
        .EXP_W  (8),
        .MANT_W (23),
        .BIAS   (127),
        .TAG_W  (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_exp_a         (in_exp_a),
        .in_exp_b         (in_exp_b),
        .in_tag           (in_tag),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_exp          (out_exp),
        .out_denorm_shift (out_denorm_shift),
        .out_denorm       (out_denorm),
        .out_ftz          (out_ftz),
        .out_inf          (out_inf),
        .out_overflow     (out_overflow),
        .out_tag          (out_tag)
    );

    always #5 clk = ~clk;

    function automatic res_t actual();
        res_t r;
        r.e   = out_exp;
        r.sh  = out_denorm_shift;
        r.dn  = out_denorm;
        r.ftz = out_ftz;
        r.inf = out_inf;
        r.ovf = out_overflow;
        r.tag = out_tag;
        return r;
    endfunction

    // Reference: product exponent rules written directly in integer arithmetic
    function automatic res_t model(input int a, input int b, input int tag);
        res_t r;
        int   s;
        r     = '0;
        r.tag = 4'(tag);
        s     = a + b - 127;
        if (s <= 0) begin
            r.dn = 1'b1;
            if (1 - s > 24) begin
                r.sh  = 5'd25;
                r.ftz = 1'b1;
            end else begin
                r.sh = 5'(1 - s);
            end
        end else begin
            r.e = 8'(s % 256);
            if (s == 255) r.inf = 1'b1;
            else if (s >= 256) r.ovf = 1'b1;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Issue one beat; expectation is pushed on the edge it is accepted
    task automatic send(input int a, input int b, input int tag);
        int cnt;
        cnt      = 0;
        in_valid = 1'b1;
        in_exp_a = 8'(a);
        in_exp_b = 8'(b);
        in_tag   = 4'(tag);
        forever begin
            @(negedge clk);
            if (in_ready) break;
            cnt++;
            if (cnt > 500) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", cnt);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        q.push_back(model(a, b, tag));
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while (q.size() != 0 && cnt < 200) begin
            @(posedge clk);
            cnt++;
        end
        #1;
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    // Random backpressure, active only in the random phase
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops and compares each transferred beat, checks stall stability
    initial begin
        res_t act;
        res_t prev_act;
        bit   prev_stall;
        prev_stall = 1'b0;
        prev_act   = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                act = actual();
                if (prev_stall && out_valid) check("hold_stable", 64'(act), 64'(prev_act));
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_beat: got out_valid=1 tag=%0d, expected no beat",
                                 out_tag);
                    end else begin
                        check("beat", 64'(act), 64'(q.pop_front()));
                    end
                    n_out++;
                end
                prev_stall = out_valid && !out_ready;
                prev_act   = act;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        int base;
        int seen;
        int a;
        int b;
        int corners[6];
        corners = '{0, 1, 104, 127, 128, 255};

        // Reset state
        #3;
        check("reset_outputs", {in_ready, out_valid, 21'(actual())}, 64'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {in_ready, out_valid}, 64'b10);

        // Latency with an idle pipe and no backpressure
        out_ready = 1'b1;
        send(127, 127, 1);
        @(negedge clk);
        check("latency_s1", out_valid, 64'd0);
        @(negedge clk);
        check("latency_s2", out_valid, 64'd1);
        @(posedge clk);
        #1;

        // Directed classification points, back to back
        send(127, 0, 2);
        send(100, 20, 3);
        send(1, 1, 4);
        send(200, 182, 5);
        send(255, 255, 6);
        send(104, 0, 7);
        send(103, 0, 8);
        send(254, 128, 9);
        drain();

        // Backpressure: at most two beats held, order and tags preserved
        base      = n_out;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(120 + i * 3, 10 + i, 10 + i);
            end
            begin
                repeat (4) @(posedge clk);
                #2;
                check("stall_in_ready", in_ready, 64'd0);
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_count", 64'(n_out - base), 64'd5);

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(130, 130, 1);
        send(131, 131, 2);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_outputs", {in_ready, out_valid, 21'(actual())}, 64'd0);
        q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_stale_after_reset", 64'(seen), 64'd0);

        // Flush with a full pipe
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(140, 10, 3);
        send(141, 11, 4);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        q.delete();
        @(negedge clk);
        check("flush_clear", {out_valid, in_ready}, 64'b01);

        // Flush coincident with an input beat: ready still reported, beat dropped
        @(posedge clk);
        #1 out_ready = 1'b1;
        in_valid = 1'b1;
        in_exp_a = 8'd150;
        in_exp_b = 8'd20;
        in_tag   = 4'd5;
        flush    = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 64'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_drop", 64'(seen), 64'd0);
        @(posedge clk);
        #1;

        // Randomised traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)]
                                            : int'($urandom_range(0, 255));
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)]
                                            : int'($urandom_range(0, 255));
            send(a, b, int'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit
    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

endmodule
